// File: rtl/ysyx_22040750_mdu_ctrl.sv
// Iterative 1-bit/cycle multiply / restoring-divide unit with EX-stage stall sequencing.
// Optional feature macro: MDU_EARLY_FINISH_EN (MUL/MULH stop once remaining multiplier bits are zero).
module ysyx_22040750_mdu_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            I_sys_clk,
  input  logic            I_rst,
  input  logic            I_valid,
  input  logic [3:0]      I_op,
  input  logic [1:0]      I_sext,
  input  logic            I_word,
  input  logic [XLEN-1:0] I_opnum1,
  input  logic [XLEN-1:0] I_opnum2,
  input  logic            I_flush,
  output logic            O_ready,
  output logic            O_stall,
  output logic            O_out_valid,
  output logic [XLEN-1:0] O_result
);
  localparam int HW = XLEN / 2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {OP_MUL = 2'd0, OP_MULH = 2'd1, OP_DIV = 2'd2, OP_REM = 2'd3} op_t;

  state_t            r_state, w_state_nxt;
  op_t               r_op, w_op_sel;
  logic              r_word, r_neg_a, r_neg_b, r_out_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc, r_mcand;
  logic [XLEN-1:0]   r_mplier, r_rem, r_quo, r_div, r_result;

  logic              w_accept, w_is_div, w_dz, w_a_neg, w_b_neg, w_last, w_finish, w_ge;
  logic [XLEN-1:0]   w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_dz_res;
  logic [2*XLEN-1:0] w_acc_nxt, w_prod;
  logic [XLEN-1:0]   w_mplier_nxt, w_rem_nxt, w_quo_nxt, w_quo_s, w_rem_s, w_raw, w_final;
  logic [XLEN:0]     w_shift;
  logic [CNT_W-1:0]  w_last_cnt;

  function automatic logic [XLEN-1:0] word_sext(input logic [HW-1:0] v);
    return {{(XLEN-HW){v[HW-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] word_zext(input logic [HW-1:0] v);
    return {{(XLEN-HW){1'b0}}, v};
  endfunction

  // Operand preparation: priority decode, word masking, magnitude and sign capture
  always_comb begin
    if (I_op[0])      w_op_sel = OP_MUL;
    else if (I_op[1]) w_op_sel = OP_MULH;
    else if (I_op[2]) w_op_sel = OP_DIV;
    else              w_op_sel = OP_REM;
    w_a_ext  = I_word ? (I_sext[1] ? word_sext(I_opnum1[HW-1:0]) : word_zext(I_opnum1[HW-1:0])) : I_opnum1;
    w_b_ext  = I_word ? (I_sext[0] ? word_sext(I_opnum2[HW-1:0]) : word_zext(I_opnum2[HW-1:0])) : I_opnum2;
    w_a_neg  = I_sext[1] & w_a_ext[XLEN-1];
    w_b_neg  = I_sext[0] & w_b_ext[XLEN-1];
    w_a_abs  = w_a_neg ? ({XLEN{1'b0}} - w_a_ext) : w_a_ext;
    w_b_abs  = w_b_neg ? ({XLEN{1'b0}} - w_b_ext) : w_b_ext;
    w_is_div = (w_op_sel == OP_DIV) || (w_op_sel == OP_REM);
    w_dz     = w_is_div && (w_b_ext == {XLEN{1'b0}});
    w_dz_res = (w_op_sel == OP_DIV) ? {XLEN{1'b1}} : (I_word ? word_sext(I_opnum1[HW-1:0]) : I_opnum1);
    w_accept = (r_state == S_IDLE) && I_valid && (|I_op) && !I_flush;
  end

  // One iteration of both datapaths plus the sign-fixed result seen on the final iteration
  always_comb begin
    w_acc_nxt    = r_acc + (r_mplier[0] ? r_mcand : {(2*XLEN){1'b0}});
    w_mplier_nxt = {1'b0, r_mplier[XLEN-1:1]};
    w_shift      = {r_rem, r_quo[XLEN-1]};
    w_ge         = (w_shift >= {1'b0, r_div});
    w_rem_nxt    = w_ge ? (w_shift[XLEN-1:0] - r_div) : w_shift[XLEN-1:0];
    w_quo_nxt    = {r_quo[XLEN-2:0], w_ge};
    w_last_cnt   = r_word ? CNT_W'(HW - 1) : CNT_W'(XLEN - 1);
    w_last       = (r_cnt == w_last_cnt);
`ifdef MDU_EARLY_FINISH_EN
    w_finish     = w_last || (((r_op == OP_MUL) || (r_op == OP_MULH)) && (w_mplier_nxt == {XLEN{1'b0}}));
`else
    w_finish     = w_last;
`endif
    w_prod       = (r_neg_a ^ r_neg_b) ? ({(2*XLEN){1'b0}} - w_acc_nxt) : w_acc_nxt;
    w_quo_s      = (r_neg_a ^ r_neg_b) ? ({XLEN{1'b0}} - w_quo_nxt) : w_quo_nxt;
    w_rem_s      = r_neg_a ? ({XLEN{1'b0}} - w_rem_nxt) : w_rem_nxt;
    case (r_op)
      OP_MUL:  w_raw = w_prod[XLEN-1:0];
      OP_MULH: w_raw = w_prod[2*XLEN-1:XLEN];
      OP_DIV:  w_raw = w_quo_s;
      OP_REM:  w_raw = w_rem_s;
      default: w_raw = w_prod[XLEN-1:0];
    endcase
    w_final = r_word ? word_sext(w_raw[HW-1:0]) : w_raw;
  end

  // Next-state logic and handshake outputs; reset forces ready/stall low
  always_comb begin
    w_state_nxt = r_state;
    if (I_rst || I_flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = w_accept ? (w_dz ? S_DONE : S_CALC) : S_IDLE;
        S_CALC:  w_state_nxt = w_finish ? S_DONE : S_CALC;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
    O_ready = !I_rst && (r_state == S_IDLE);
    O_stall = !I_rst && (((r_state == S_IDLE) && I_valid && (|I_op)) || (r_state == S_CALC));
  end

  // State register
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Operand latching, iteration registers and registered result
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_cnt <= {CNT_W{1'b0}}; r_out_valid <= 1'b0; r_result <= {XLEN{1'b0}};
      r_op <= OP_MUL; r_word <= 1'b0; r_neg_a <= 1'b0; r_neg_b <= 1'b0;
      r_acc <= {(2*XLEN){1'b0}}; r_mcand <= {(2*XLEN){1'b0}}; r_mplier <= {XLEN{1'b0}};
      r_rem <= {XLEN{1'b0}}; r_quo <= {XLEN{1'b0}}; r_div <= {XLEN{1'b0}};
    end else if (I_flush) begin
      r_cnt       <= {CNT_W{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt       <= {CNT_W{1'b0}};
          r_out_valid <= 1'b0;
          if (w_accept) begin
            r_op     <= w_op_sel;
            r_word   <= I_word;
            r_neg_a  <= w_a_neg;
            r_neg_b  <= w_b_neg;
            r_acc    <= {(2*XLEN){1'b0}};
            r_mcand  <= {{XLEN{1'b0}}, w_a_abs};
            r_mplier <= w_b_abs;
            r_rem    <= {XLEN{1'b0}};
            // word dividends start in the upper half so the MSB-first shift sees them first
            r_quo    <= I_word ? {w_a_abs[HW-1:0], {(XLEN-HW){1'b0}}} : w_a_abs;
            r_div    <= w_b_abs;
            if (w_dz) begin
              r_result    <= w_dz_res;
              r_out_valid <= 1'b1;
            end else begin
              r_result    <= r_result;
            end
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
          r_mplier <= w_mplier_nxt;
          r_rem    <= w_rem_nxt;
          r_quo    <= w_quo_nxt;
          if (w_finish) begin
            r_cnt       <= {CNT_W{1'b0}};
            r_result    <= w_final;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt       <= r_cnt + CNT_W'(1);
            r_out_valid <= 1'b0;
          end
        end
        S_DONE:  r_out_valid <= 1'b0;
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign O_out_valid = r_out_valid;
  assign O_result    = r_result;

endmodule
